store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- Sits directly downstream of the address-generate stage and beside the memory-access stage.
- Captures each aligned store leaving address generation (address, lane-aligned data, byte mask, ROB tag) into an in-order circular buffer.
- Marks each store committed when the ROB retires it, then drains committed stores to the D-cache over a req/ack handshake.
- Forwards store data to younger loads, and reports buffer occupancy and non-idempotent status back to pipeline control.

Parameters:
DEPTH, 8, number of entries (power of two, >=2)
ROB_TAG_W, 5, ROB tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
agu_valid  in  1  AGU output instruction valid
agu_is_store  in  1  AGU instruction is a store
agu_align_exc  in  1  AGU memory-align exception
agu_addr  in  32  access address
agu_data  in  32  lane-aligned store data
agu_byte_sel  in  4  byte mask
agu_non_idem  in  1  address is in the non-idempotent region
agu_rob_tag  in  ROB_TAG_W  ROB tag
full  out  1  no free entry; AGU must stall
commit_valid  in  1  ROB retires a store this cycle
commit_rob_tag  in  ROB_TAG_W  tag of the retired store
spec_flush  in  1  discard all uncommitted entries
dc_req  out  1  D-cache write request
dc_addr  out  32  word-aligned write address
dc_data  out  32  write data
dc_byte_sel  out  4  write byte enables
dc_ack  in  1  D-cache accepted the write
ld_addr  in  32  load address (forward lookup)
ld_byte_sel  in  4  load byte mask
fwd_hit  out  1  youngest matching store fully covers the load
fwd_data  out  32  forwarded data
fwd_conflict  out  1  partial overlap; load must replay
non_idempotent_instr_exists  out  1  some valid entry is non-idempotent
empty  out  1  no valid entries
commit_err  out  1  sticky: commit tag mismatch

Behaviour:
- Reset is asynchronous and active-high: head, commit and tail pointers go to 0, all valid/committed bits clear, commit_err=0, dc_req=0, empty=1, full=0.
- Pointers are log2(DEPTH)+1 bits, with the wrap bit used to tell full from empty. empty when tail==head. full when the index bits are equal and the wrap bits differ.
- Allocate: when agu_valid && agu_is_store && !agu_align_exc && !full, write an entry at tail (committed=0) and advance tail. Allocation while full is dropped; AGU is required to stall on full. The entry is visible to forwarding the next cycle.
- Commit: when commit_valid, the entry at the commit pointer is required to be valid, uncommitted, and carry rob_tag==commit_rob_tag. On a match, set committed and advance the commit pointer. On a mismatch, set commit_err (sticky until reset) and make no pointer change.
- Drain: dc_req is asserted while the head entry is valid and committed.
  - dc_addr = {addr[31:2],2'b00}; dc_data and dc_byte_sel come from the head entry.
  - Outputs hold stable until dc_ack. When dc_req && dc_ack, clear the head entry and advance head.
  - Back-to-back drains are allowed: one per cycle when ack is held high.
- spec_flush: set tail = commit pointer and clear the valid bits of all uncommitted entries. Committed entries keep draining.
  - An allocation in the same cycle as spec_flush is discarded.
  - A commit in the same cycle is applied first, so the committed entry survives.
- Simultaneous allocate + drain while full: allocation is still refused, because full is registered-state based.
- Forwarding is combinational and searches all valid entries, youngest to oldest (tail-1 back to head, wrap-aware). The first entry with addr[31:2]==ld_addr[31:2] and (byte_sel & ld_byte_sel)!=0 decides the result:
  - if (entry.byte_sel & ld_byte_sel)==ld_byte_sel: fwd_hit=1, fwd_data=entry data.
  - otherwise: fwd_conflict=1, fwd_hit=0.
  - If no entry matches, both flags are 0 and fwd_data=0.
- non_idempotent_instr_exists is the OR of valid&non_idem over all entries.
- Latency: allocate to earliest dc_req is 2 cycles (allocate, then commit, then request). With no stall, one store retires per cycle.

Test Plan:
- Reset, then allocate a store with addr 0x1000_0004, data 0xAABBCCDD, byte_sel 1111, tag 3 -> empty=0, dc_req=0. Commit tag 3 -> next cycle dc_req=1, dc_addr=0x1000_0004. dc_ack -> empty=1.
- Allocate 8 stores with no commit -> full=1 after the 8th. A 9th agu_valid is ignored. Commit and drain 1 -> full=0. Pointers wrap correctly over 3 full rounds.
- Store SB 0x2000_0001 (byte_sel 0010, data 0x0000_5500), then load ld_addr 0x2000_0001, byte_sel 0010 -> fwd_hit=1, fwd_data=0x0000_5500. Same store, load byte_sel 1111 -> fwd_conflict=1. Two stores to the same word -> the youngest supplies the data.
- 5 stores allocated, 2 committed, spec_flush -> tail=commit pointer, only 2 drain, then empty=1. spec_flush together with a commit of the 3rd -> 3 drain.
- Commit with a wrong tag -> commit_err=1 and the entry stays uncommitted. Allocate a non_idem store -> non_idempotent_instr_exists=1 until it drains.
- Assert rst asynchronously mid-drain, with dc_req=1 and ack low -> dc_req, full and commit_err drop immediately, and empty=1.

Source files
------------

// File: rtl/store_commit_buffer.sv
// In-order store buffer: captures AGU stores, marks them committed on ROB retire,
// drains committed stores to the D-cache and forwards store data to younger loads.
module store_commit_buffer #(
  parameter int DEPTH     = 8,
  parameter int ROB_TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 agu_valid,
  input  logic                 agu_is_store,
  input  logic                 agu_align_exc,
  input  logic [31:0]          agu_addr,
  input  logic [31:0]          agu_data,
  input  logic [3:0]           agu_byte_sel,
  input  logic                 agu_non_idem,
  input  logic [ROB_TAG_W-1:0] agu_rob_tag,
  output logic                 full,
  input  logic                 commit_valid,
  input  logic [ROB_TAG_W-1:0] commit_rob_tag,
  input  logic                 spec_flush,
  output logic                 dc_req,
  output logic [31:0]          dc_addr,
  output logic [31:0]          dc_data,
  output logic [3:0]           dc_byte_sel,
  input  logic                 dc_ack,
  input  logic [31:0]          ld_addr,
  input  logic [3:0]           ld_byte_sel,
  output logic                 fwd_hit,
  output logic [31:0]          fwd_data,
  output logic                 fwd_conflict,
  output logic                 non_idempotent_instr_exists,
  output logic                 empty,
  output logic                 commit_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]     r_head, r_commit, r_tail;
  logic [DEPTH-1:0]     r_valid, r_committed, r_nonIdem;
  logic [29:0]          r_addrWord [DEPTH];
  logic [31:0]          r_data     [DEPTH];
  logic [3:0]           r_byteSel  [DEPTH];
  logic [ROB_TAG_W-1:0] r_robTag   [DEPTH];
  logic                 r_commitErr;

  logic [IDX_W-1:0] w_headIdx, w_commitIdx, w_tailIdx;
  logic [PTR_W-1:0] w_count, w_commitNext;
  logic             w_alloc, w_commitOk, w_drain, w_unusedAddrBits;

  assign w_headIdx   = r_head[IDX_W-1:0];
  assign w_commitIdx = r_commit[IDX_W-1:0];
  assign w_tailIdx   = r_tail[IDX_W-1:0];
  assign w_count     = r_tail - r_head;

  assign empty = (r_tail == r_head);
  assign full  = (w_tailIdx == w_headIdx) && (r_tail[IDX_W] != r_head[IDX_W]);

  assign w_alloc      = agu_valid && agu_is_store && !agu_align_exc && !full && !spec_flush;
  assign w_commitOk   = commit_valid && r_valid[w_commitIdx] && !r_committed[w_commitIdx] &&
                        (r_robTag[w_commitIdx] == commit_rob_tag);
  assign w_commitNext = w_commitOk ? r_commit + PTR_W'(1) : r_commit;

  assign dc_req      = r_valid[w_headIdx] && r_committed[w_headIdx];
  assign w_drain     = dc_req && dc_ack;
  assign dc_addr     = {r_addrWord[w_headIdx], 2'b00};
  assign dc_data     = r_data[w_headIdx];
  assign dc_byte_sel = r_byteSel[w_headIdx];

  assign non_idempotent_instr_exists = |(r_valid & r_nonIdem);
  assign commit_err                  = r_commitErr;
  assign w_unusedAddrBits            = ^{agu_addr[1:0], ld_addr[1:0]};

  // A commit in the flush cycle lands first, so tail snaps to the post-commit pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_commit    <= '0;
      r_tail      <= '0;
      r_valid     <= '0;
      r_committed <= '0;
      r_commitErr <= 1'b0;
    end else begin
      if (commit_valid && !w_commitOk) r_commitErr <= 1'b1;
      if (w_commitOk) r_committed[w_commitIdx] <= 1'b1;
      r_commit <= w_commitNext;
      if (w_drain) begin
        r_valid[w_headIdx]     <= 1'b0;
        r_committed[w_headIdx] <= 1'b0;
        r_head                 <= r_head + PTR_W'(1);
      end
      if (spec_flush) begin
        r_tail <= w_commitNext;
        for (int i = 0; i < DEPTH; i++) begin
          if (!r_committed[i] && !(w_commitOk && (IDX_W'(i) == w_commitIdx)))
            r_valid[i] <= 1'b0;
        end
      end else if (w_alloc) begin
        r_valid[w_tailIdx]     <= 1'b1;
        r_committed[w_tailIdx] <= 1'b0;
        r_tail                 <= r_tail + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addrWord[w_tailIdx] <= agu_addr[31:2];
      r_data[w_tailIdx]     <= agu_data;
      r_byteSel[w_tailIdx]  <= agu_byte_sel;
      r_robTag[w_tailIdx]   <= agu_rob_tag;
      r_nonIdem[w_tailIdx]  <= agu_non_idem;
    end
  end

  // Walk oldest to youngest so the youngest overlapping store has the last word.
  always_comb begin
    logic [IDX_W-1:0] scanIdx;
    scanIdx      = '0;
    fwd_hit      = 1'b0;
    fwd_conflict = 1'b0;
    fwd_data     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = w_headIdx + IDX_W'(k);
      if ((PTR_W'(k) < w_count) && r_valid[scanIdx] &&
          (r_addrWord[scanIdx] == ld_addr[31:2]) &&
          ((r_byteSel[scanIdx] & ld_byte_sel) != 4'b0000)) begin
        if ((r_byteSel[scanIdx] & ld_byte_sel) == ld_byte_sel) begin
          fwd_hit      = 1'b1;
          fwd_conflict = 1'b0;
          fwd_data     = r_data[scanIdx];
        end else begin
          fwd_hit      = 1'b0;
          fwd_conflict = 1'b1;
          fwd_data     = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed scenarios plus a random
// phase, all checked against a queue-based model of the store buffer.
module tb_store_commit_buffer;
  localparam int DEPTH = 8;
  localparam int TW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          agu_valid, agu_is_store, agu_align_exc, agu_non_idem;
  logic [31:0]   agu_addr, agu_data;
  logic [3:0]    agu_byte_sel;
  logic [TW-1:0] agu_rob_tag;
  logic          full;
  logic          commit_valid;
  logic [TW-1:0] commit_rob_tag;
  logic          spec_flush;
  logic          dc_req;
  logic [31:0]   dc_addr, dc_data;
  logic [3:0]    dc_byte_sel;
  logic          dc_ack;
  logic [31:0]   ld_addr;
  logic [3:0]    ld_byte_sel;
  logic          fwd_hit, fwd_conflict;
  logic [31:0]   fwd_data;
  logic          non_idempotent_instr_exists, empty, commit_err;

  int testCount = 0;
  int failCount = 0;
  int drains;

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [3:0]    bsel;
    logic [TW-1:0] tag;
    logic          nonIdem;
    logic          committed;
  } entry_t;

  // Model: oldest store at index 0; uncommitted stores always sit at the back.
  entry_t q[$];
  logic   modelErr = 1'b0;

  always #5 clk = ~clk;

  store_commit_buffer #(.DEPTH(DEPTH), .ROB_TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .agu_valid(agu_valid), .agu_is_store(agu_is_store), .agu_align_exc(agu_align_exc),
    .agu_addr(agu_addr), .agu_data(agu_data), .agu_byte_sel(agu_byte_sel),
    .agu_non_idem(agu_non_idem), .agu_rob_tag(agu_rob_tag), .full(full),
    .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag), .spec_flush(spec_flush),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_data(dc_data), .dc_byte_sel(dc_byte_sel),
    .dc_ack(dc_ack), .ld_addr(ld_addr), .ld_byte_sel(ld_byte_sel),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_conflict(fwd_conflict),
    .non_idempotent_instr_exists(non_idempotent_instr_exists),
    .empty(empty), .commit_err(commit_err)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int committedCount();
    int n = 0;
    foreach (q[j]) if (q[j].committed) n++;
    return n;
  endfunction

  task automatic idleInputs();
    agu_valid     = 1'b0;
    agu_is_store  = 1'b0;
    agu_align_exc = 1'b0;
    agu_non_idem  = 1'b0;
    commit_valid  = 1'b0;
    spec_flush    = 1'b0;
    dc_ack        = 1'b0;
  endtask

  task automatic setAlloc(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] bsel, input logic [TW-1:0] tag, input logic ni);
    agu_valid     = 1'b1;
    agu_is_store  = 1'b1;
    agu_align_exc = 1'b0;
    agu_addr      = addr;
    agu_data      = data;
    agu_byte_sel  = bsel;
    agu_rob_tag   = tag;
    agu_non_idem  = ni;
  endtask

  // Retire the oldest uncommitted store the model knows about, if any.
  task automatic commitNext();
    int ci;
    ci = committedCount();
    if (ci < q.size()) begin
      commit_valid   = 1'b1;
      commit_rob_tag = q[ci].tag;
    end
  endtask

  // Compare every output against what the model says the buffer should show now.
  task automatic checkOutput();
    logic        expHit, expConf, expNi, expReq, decided;
    logic [31:0] expData;
    expHit = 1'b0; expConf = 1'b0; expNi = 1'b0; expData = '0; decided = 1'b0;
    foreach (q[j]) expNi |= q[j].nonIdem;
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (!decided && q[j].addr[31:2] == ld_addr[31:2] && (q[j].bsel & ld_byte_sel) != 4'b0) begin
        decided = 1'b1;
        if ((q[j].bsel & ld_byte_sel) == ld_byte_sel) begin
          expHit  = 1'b1;
          expData = q[j].data;
        end else begin
          expConf = 1'b1;
        end
      end
    end
    expReq = (q.size() > 0) && q[0].committed;
    checkVal("empty", empty, q.size() == 0);
    checkVal("full", full, q.size() == DEPTH);
    checkVal("dc_req", dc_req, expReq);
    checkVal("commit_err", commit_err, modelErr);
    checkVal("non_idem", non_idempotent_instr_exists, expNi);
    checkVal("fwd_hit", fwd_hit, expHit);
    checkVal("fwd_conflict", fwd_conflict, expConf);
    if (!expConf) checkVal("fwd_data", fwd_data, expData);
    if (expReq) begin
      checkVal("dc_addr", dc_addr, {q[0].addr[31:2], 2'b00});
      checkVal("dc_data", dc_data, q[0].data);
      checkVal("dc_byte_sel", dc_byte_sel, q[0].bsel);
    end
  endtask

  // Advance the model across one clock edge using the inputs the DUT just sampled.
  task automatic updateModel();
    int     ci;
    logic   fullBefore, reqBefore;
    entry_t e;
    fullBefore = (q.size() == DEPTH);
    reqBefore  = (q.size() > 0) && q[0].committed;
    if (commit_valid) begin
      ci = committedCount();
      if (ci < q.size() && q[ci].tag == commit_rob_tag) begin
        e = q[ci];
        e.committed = 1'b1;
        q[ci] = e;
      end else begin
        modelErr = 1'b1;
      end
    end
    if (reqBefore && dc_ack) void'(q.pop_front());
    if (spec_flush) begin
      while (q.size() > 0 && !q[q.size()-1].committed) void'(q.pop_back());
    end else if (agu_valid && agu_is_store && !agu_align_exc && !fullBefore) begin
      e.addr = agu_addr; e.data = agu_data; e.bsel = agu_byte_sel;
      e.tag = agu_rob_tag; e.nonIdem = agu_non_idem; e.committed = 1'b0;
      q.push_back(e);
    end
  endtask

  // One clock: check at the falling edge, then step DUT and model together.
  task automatic applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    idleInputs();
    q.delete();
    modelErr = 1'b0;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drainAll();
    for (int c = 0; c < 4 * DEPTH && q.size() > 0; c++) begin
      idleInputs();
      commitNext();
      dc_ack = 1'b1;
      applyStimulus();
    end
    idleInputs();
    checkVal("drainAll_empty", empty, 1'b1);
  endtask

  initial begin
    agu_addr = '0; agu_data = '0; agu_byte_sel = '0; agu_rob_tag = '0;
    commit_rob_tag = '0; ld_addr = '0; ld_byte_sel = '0;
    idleInputs();
    resetDut();

    // Single store: allocate, commit, hold request without ack, then drain.
    setAlloc(32'h1000_0004, 32'hAABB_CCDD, 4'hF, 5'd3, 1'b0);
    applyStimulus();
    idleInputs();
    checkVal("t1_notEmpty", empty, 1'b0);
    checkVal("t1_noReq", dc_req, 1'b0);
    commit_valid = 1'b1; commit_rob_tag = 5'd3;
    applyStimulus();
    idleInputs();
    checkVal("t1_req", dc_req, 1'b1);
    checkVal("t1_dcAddr", dc_addr, 32'h1000_0004);
    checkVal("t1_dcData", dc_data, 32'hAABB_CCDD);
    applyStimulus();
    checkVal("t1_reqHeld", dc_req, 1'b1);
    dc_ack = 1'b1;
    applyStimulus();
    idleInputs();
    checkVal("t1_emptyAfterAck", empty, 1'b1);

    // Fill to full, try a ninth allocation, then free one slot.
    for (int i = 0; i < DEPTH; i++) begin
      setAlloc(32'h4000_0000 + 32'(i) * 4, $urandom, 4'hF, TW'(i), 1'b0);
      applyStimulus();
    end
    idleInputs();
    checkVal("t2_full", full, 1'b1);
    setAlloc(32'h4000_0100, 32'hDEAD_BEEF, 4'hF, 5'd20, 1'b0);
    applyStimulus();
    idleInputs();
    checkVal("t2_fullAfterDrop", full, 1'b1);
    commitNext();
    applyStimulus();
    idleInputs();
    dc_ack = 1'b1;
    applyStimulus();
    idleInputs();
    checkVal("t2_notFull", full, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < DEPTH && q.size() < DEPTH; c++) begin
        setAlloc(32'h4100_0000 + 32'($urandom_range(0, 255)) * 4, $urandom,
                 4'($urandom_range(1, 15)), TW'($urandom_range(0, 31)), 1'b0);
        applyStimulus();
      end
      idleInputs();
      checkVal("t2_roundFull", full, 1'b1);
      drainAll();
    end

    // Forwarding: exact hit, partial overlap, youngest-wins, miss.
    setAlloc(32'h2000_0001, 32'h0000_5500, 4'b0010, 5'd4, 1'b0);
    applyStimulus();
    idleInputs();
    ld_addr = 32'h2000_0001; ld_byte_sel = 4'b0010; #1;
    checkVal("t3_hit", fwd_hit, 1'b1);
    checkVal("t3_data", fwd_data, 32'h0000_5500);
    ld_byte_sel = 4'hF; #1;
    checkVal("t3_conflict", fwd_conflict, 1'b1);
    checkVal("t3_conflictNoHit", fwd_hit, 1'b0);
    setAlloc(32'h2000_0000, 32'h0000_7700, 4'b0010, 5'd5, 1'b0);
    applyStimulus();
    idleInputs();
    ld_byte_sel = 4'b0010; #1;
    checkVal("t3_youngest", fwd_data, 32'h0000_7700);
    ld_addr = 32'h2000_0004; #1;
    checkVal("t3_missHit", fwd_hit, 1'b0);
    checkVal("t3_missData", fwd_data, 32'h0);
    drainAll();

    // Flush after two commits (with a same-cycle allocation that must vanish).
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        setAlloc(32'h5000_0000 + 32'(i) * 4, $urandom, 4'hF, TW'(10 + 5 * pass + i), 1'b0);
        applyStimulus();
      end
      for (int i = 0; i < 2; i++) begin
        idleInputs();
        commitNext();
        applyStimulus();
      end
      idleInputs();
      if (pass == 1) commitNext();
      else setAlloc(32'h5000_0100, 32'h1234_5678, 4'hF, 5'd30, 1'b0);
      spec_flush = 1'b1;
      applyStimulus();
      drains = 0;
      for (int c = 0; c < 10; c++) begin
        idleInputs();
        if (dc_req) drains++;
        dc_ack = 1'b1;
        applyStimulus();
      end
      idleInputs();
      checkVal("t4_drainCount", drains, 2 + pass);
      checkVal("t4_empty", empty, 1'b1);
    end

    // Wrong commit tag, then a non-idempotent store retiring behind it.
    setAlloc(32'h6000_0000, $urandom, 4'hF, 5'd9, 1'b0);
    applyStimulus();
    idleInputs();
    commit_valid = 1'b1; commit_rob_tag = 5'd10;
    applyStimulus();
    idleInputs();
    checkVal("t5_commitErr", commit_err, 1'b1);
    applyStimulus();
    checkVal("t5_stillUncommitted", dc_req, 1'b0);
    setAlloc(32'h6000_0010, $urandom, 4'hF, 5'd11, 1'b1);
    applyStimulus();
    idleInputs();
    checkVal("t5_nonIdem", non_idempotent_instr_exists, 1'b1);
    commitNext();
    applyStimulus();
    idleInputs();
    commitNext();
    dc_ack = 1'b1;
    applyStimulus();
    idleInputs();
    checkVal("t5_nonIdemHeld", non_idempotent_instr_exists, 1'b1);
    dc_ack = 1'b1;
    applyStimulus();
    idleInputs();
    checkVal("t5_nonIdemGone", non_idempotent_instr_exists, 1'b0);
    checkVal("t5_errSticky", commit_err, 1'b1);

    // Random traffic against the model.
    resetDut();
    for (int c = 0; c < 400; c++) begin
      idleInputs();
      if ($urandom_range(0, 99) < 60) begin
        agu_valid     = 1'b1;
        agu_is_store  = ($urandom_range(0, 9) != 0);
        agu_align_exc = ($urandom_range(0, 9) == 0);
        agu_addr      = 32'h3000_0000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
        agu_data      = $urandom;
        agu_byte_sel  = 4'($urandom_range(1, 15));
        agu_rob_tag   = TW'($urandom_range(0, 31));
        agu_non_idem  = ($urandom_range(0, 6) == 0);
      end
      if ($urandom_range(0, 1) == 1) commitNext();
      dc_ack      = ($urandom_range(0, 99) < 60);
      spec_flush  = ($urandom_range(0, 99) < 4);
      ld_addr     = 32'h3000_0000 + 32'($urandom_range(0, 4)) * 4;
      ld_byte_sel = 4'($urandom_range(1, 15));
      applyStimulus();
    end
    drainAll();

    // Asynchronous reset in the middle of a stalled drain.
    resetDut();
    for (int i = 0; i < DEPTH; i++) begin
      setAlloc(32'h7000_0000 + 32'(i) * 4, $urandom, 4'hF, TW'(i), 1'b0);
      applyStimulus();
    end
    idleInputs();
    commitNext();
    applyStimulus();
    idleInputs();
    commit_valid = 1'b1; commit_rob_tag = q[1].tag ^ 5'h1F;
    applyStimulus();
    idleInputs();
    checkVal("t6_reqBefore", dc_req, 1'b1);
    checkVal("t6_fullBefore", full, 1'b1);
    checkVal("t6_errBefore", commit_err, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkVal("t6_reqAsync", dc_req, 1'b0);
    checkVal("t6_fullAsync", full, 1'b0);
    checkVal("t6_errAsync", commit_err, 1'b0);
    checkVal("t6_emptyAsync", empty, 1'b1);
    q.delete();
    modelErr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
